// File: rtl/access_decision_fsm.sv
// Access decision controller sitting behind floor_id_logic.
// Evaluates an ID submission, optionally offers the alternative floor,
// emits a single-cycle action_taken code and holds the gate or deny
// indicator for a fixed number of cycles before returning to idle.
module access_decision_fsm #(
  parameter int TIMER_W      = 16,
  parameter int OFFER_CYCLES = 1000,
  parameter int GATE_CYCLES  = 500,
  parameter int DENY_CYCLES  = 250
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] MODE,
  input  logic       id_submit,
  input  logic       id_valid,
  input  logic       id_special,
  input  logic       chosen_flr_full,
  input  logic       alternative_flr_full,
  input  logic       spec_flr_full,
  input  logic       accept_alt,
  input  logic       reject_alt,
  output logic [1:0] action_taken,
  output logic       gate_open,
  output logic       deny,
  output logic       offer_alt,
  output logic       busy,
  output logic [2:0] reason
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_OFFER_ALT,
    ST_COMMIT,
    ST_GATE,
    ST_DENY
  } state_t;

  localparam logic [TIMER_W-1:0] OFFER_LOAD = TIMER_W'(OFFER_CYCLES);
  localparam logic [TIMER_W-1:0] GATE_LOAD  = TIMER_W'(GATE_CYCLES);
  localparam logic [TIMER_W-1:0] DENY_LOAD  = TIMER_W'(DENY_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  localparam logic [2:0] RSN_NONE     = 3'd0;
  localparam logic [2:0] RSN_OK       = 3'd1;
  localparam logic [2:0] RSN_INVALID  = 3'd2;
  localparam logic [2:0] RSN_FULL     = 3'd3;
  localparam logic [2:0] RSN_DECLINED = 3'd4;
  localparam logic [2:0] RSN_TIMEOUT  = 3'd5;
  localparam logic [2:0] RSN_ABORTED  = 3'd6;

  localparam logic [1:0] CODE_ALT    = 2'd1;
  localparam logic [1:0] CODE_CHOSEN = 2'd2;
  localparam logic [1:0] CODE_EXIT   = 2'd3;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         mode_q;
  logic [1:0]         code_q;
  logic               mode_abort;

  // The driver changing the mode selector mid-transaction aborts it.
  assign mode_abort = (MODE != mode_q);

  // Transaction sequencer; every output is a register updated alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      timer        <= '0;
      mode_q       <= '0;
      code_q       <= '0;
      action_taken <= '0;
      gate_open    <= 1'b0;
      deny         <= 1'b0;
      offer_alt    <= 1'b0;
      busy         <= 1'b0;
      reason       <= RSN_NONE;
    end else begin
      action_taken <= '0;
      case (state)
        ST_IDLE: begin
          if (id_submit && !MODE[1]) begin
            mode_q <= MODE;
            reason <= RSN_NONE;
            busy   <= 1'b1;
            timer  <= '0;
            state  <= ST_EVAL;
          end
        end

        ST_EVAL: begin
          if (mode_abort) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_ABORTED;
          end else if (mode_q == 2'd1) begin
            if (id_valid) begin
              state <= ST_COMMIT; code_q <= CODE_EXIT;
            end else begin
              state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_INVALID;
            end
          end else if (id_special) begin
            if (spec_flr_full) begin
              state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_FULL;
            end else begin
              state <= ST_COMMIT; code_q <= CODE_CHOSEN;
            end
          end else if (id_valid && !chosen_flr_full) begin
            state <= ST_COMMIT; code_q <= CODE_CHOSEN;
          end else if (id_valid && !alternative_flr_full) begin
            state <= ST_OFFER_ALT; offer_alt <= 1'b1; timer <= OFFER_LOAD;
          end else if (id_valid) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_FULL;
          end else begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_INVALID;
          end
        end

        ST_OFFER_ALT: begin
          offer_alt <= 1'b0;
          if (mode_abort) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_ABORTED;
          end else if (reject_alt) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_DECLINED;
          end else if (accept_alt) begin
            state <= ST_COMMIT; code_q <= CODE_ALT; timer <= '0;
          end else if (timer <= TIMER_ONE) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_TIMEOUT;
          end else begin
            offer_alt <= 1'b1;
            timer     <= timer - TIMER_ONE;
          end
        end

        ST_COMMIT: begin
          if (mode_abort) begin
            state <= ST_DENY; deny <= 1'b1; timer <= DENY_LOAD; reason <= RSN_ABORTED;
          end else begin
            action_taken <= code_q;
            gate_open    <= 1'b1;
            timer        <= GATE_LOAD;
            reason       <= RSN_OK;
            state        <= ST_GATE;
          end
        end

        ST_GATE: begin
          if (timer <= TIMER_ONE) begin
            gate_open <= 1'b0; busy <= 1'b0; timer <= '0; state <= ST_IDLE;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        ST_DENY: begin
          if (timer <= TIMER_ONE) begin
            deny <= 1'b0; busy <= 1'b0; timer <= '0; state <= ST_IDLE;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_access_decision_fsm.sv
// Testbench for access_decision_fsm: a timeline model schedules the expected
// output waveform of each transaction from the decision rules, and a
// per-cycle compare process checks the DUT against it.
module tb_access_decision_fsm;

  localparam int O = 12;
  localparam int G = 20;
  localparam int D = 9;
  localparam int N = 4096;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic       id_submit = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_special = 1'b0;
  logic       chosen_flr_full = 1'b0;
  logic       alternative_flr_full = 1'b0;
  logic       spec_flr_full = 1'b0;
  logic       accept_alt = 1'b0;
  logic       reject_alt = 1'b0;
  logic [1:0] action_taken;
  logic       gate_open;
  logic       deny;
  logic       offer_alt;
  logic       busy;
  logic [2:0] reason;

  access_decision_fsm #(
    .TIMER_W(16), .OFFER_CYCLES(O), .GATE_CYCLES(G), .DENY_CYCLES(D)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .id_submit(id_submit),
    .id_valid(id_valid), .id_special(id_special),
    .chosen_flr_full(chosen_flr_full), .alternative_flr_full(alternative_flr_full),
    .spec_flr_full(spec_flr_full), .accept_alt(accept_alt), .reject_alt(reject_alt),
    .action_taken(action_taken), .gate_open(gate_open), .deny(deny),
    .offer_alt(offer_alt), .busy(busy), .reason(reason)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int exp_act [N];
  bit exp_gate [N];
  bit exp_deny [N];
  bit exp_offer [N];
  bit exp_busy [N];
  int exp_reason [N];

  int gate_cnt, deny_cnt, offer_cnt, act_cnt, busy_cnt, last_act;

  // Edge counter: value k means the k-th rising edge has just happened.
  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle comparison against the scheduled waveform, plus activity counters.
  always @(negedge CLK) begin
    if (chk_en && cyc < N) begin
      checks++;
      if (action_taken !== 2'(exp_act[cyc]) || gate_open !== exp_gate[cyc] ||
          deny !== exp_deny[cyc] || offer_alt !== exp_offer[cyc] ||
          busy !== exp_busy[cyc] || reason !== 3'(exp_reason[cyc])) begin
        errors++;
        $display("[TB] FAIL cycle_cmp cyc=%0d got act=%0d gate=%0b deny=%0b offer=%0b busy=%0b reason=%0d want act=%0d gate=%0b deny=%0b offer=%0b busy=%0b reason=%0d",
                 cyc, action_taken, gate_open, deny, offer_alt, busy, reason,
                 exp_act[cyc], exp_gate[cyc], exp_deny[cyc], exp_offer[cyc],
                 exp_busy[cyc], exp_reason[cyc]);
      end
      if (gate_open) gate_cnt++;
      if (deny) deny_cnt++;
      if (offer_alt) offer_cnt++;
      if (busy) busy_cnt++;
      if (action_taken != 2'd0) begin
        act_cnt++;
        last_act = int'(action_taken);
      end
    end
  end

  // Safety net so the run always ends.
  always @(posedge CLK) begin
    if (cyc > N - 50) begin
      errors++;
      $display("[TB] FAIL watchdog cyc=%0d limit=%0d", cyc, N - 50);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  function automatic void fill_reason(int from, int r);
    for (int k = from; k < N; k++) exp_reason[k] = r;
  endfunction

  function automatic void zero_from(int from);
    for (int k = from; k < N; k++) begin
      exp_act[k] = 0; exp_gate[k] = 0; exp_deny[k] = 0;
      exp_offer[k] = 0; exp_busy[k] = 0; exp_reason[k] = 0;
    end
  endfunction

  // Denial beginning at edge e; returns the edge at which idle is reached.
  function automatic int sched_deny(int s, int e, int r);
    for (int k = e; k < e + D; k++) exp_deny[k] = 1;
    for (int k = s; k < e + D; k++) exp_busy[k] = 1;
    fill_reason(e, r);
    return e + D;
  endfunction

  // Commit state entered at edge c; code and gate appear one edge later.
  function automatic int sched_gate(int s, int c, int code);
    exp_act[c + 1] = code;
    for (int k = c + 1; k <= c + G; k++) exp_gate[k] = 1;
    for (int k = s; k <= c + G; k++) exp_busy[k] = 1;
    fill_reason(c + 1, 1);
    return c + G + 1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    id_submit = 1'b0;
    accept_alt = 1'b0;
    reject_alt = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_action"}, 16'(action_taken), 16'd0);
    checkOutput({tag, "_gate"}, 16'(gate_open), 16'd0);
    checkOutput({tag, "_deny"}, 16'(deny), 16'd0);
    checkOutput({tag, "_offer"}, 16'(offer_alt), 16'd0);
    checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
    checkOutput({tag, "_reason"}, 16'(reason), 16'd0);
  endtask

  // abort_phase: 0 none, 1 during EVAL, 2 at offer cycle abort_j, 3 during COMMIT.
  // rst_phase: 0 none, 1 reset while in COMMIT, 2 reset five cycles into GATE.
  task automatic applyStimulus(input logic [1:0] m, input logic v, input logic sp,
                               input logic cf, input logic af, input logic sf,
                               input int ans_j, input bit acc, input bit rej,
                               input int abort_phase, input int abort_j,
                               input int rst_phase, input bit dup);
    int s, c, code, stop, abort_edge, ans_edge, rst_edge, j_end, kind, e;
    logic [1:0] other;
    s = cyc + 1; c = -1; code = 0; stop = s + 2;
    abort_edge = 0; ans_edge = 0; rst_edge = -1;
    other = (m == 2'd0) ? 2'd1 : 2'd0;
    gate_cnt = 0; deny_cnt = 0; offer_cnt = 0; act_cnt = 0; busy_cnt = 0; last_act = 0;
    fill_reason(s, 0);
    exp_busy[s] = 1;
    if (abort_phase == 1) begin
      abort_edge = s + 1; stop = sched_deny(s, s + 1, 6);
    end else if (m == 2'd1) begin
      if (v) begin c = s + 1; code = 3; end
      else stop = sched_deny(s, s + 1, 2);
    end else if (sp) begin
      if (sf) stop = sched_deny(s, s + 1, 3);
      else begin c = s + 1; code = 2; end
    end else if (v && !cf) begin
      c = s + 1; code = 2;
    end else if (v && !af) begin
      j_end = O; kind = 0;
      if ((acc || rej) && ans_j <= O) begin j_end = ans_j; kind = 1; end
      if (abort_phase == 2 && abort_j <= j_end) begin j_end = abort_j; kind = 2; end
      for (int k = s + 1; k <= s + j_end; k++) exp_offer[k] = 1;
      for (int k = s; k <= s + j_end; k++) exp_busy[k] = 1;
      e = s + 1 + j_end;
      if (kind == 2) begin
        abort_edge = e; stop = sched_deny(s, e, 6);
      end else if (kind == 1) begin
        ans_edge = e;
        if (rej) stop = sched_deny(s, e, 4);
        else begin c = e; code = 1; end
      end else begin
        stop = sched_deny(s, e, 5);
      end
    end else if (v) begin
      stop = sched_deny(s, s + 1, 3);
    end else begin
      stop = sched_deny(s, s + 1, 2);
    end
    if (c >= 0) begin
      for (int k = s; k <= c; k++) exp_busy[k] = 1;
      if (abort_phase == 3) begin
        abort_edge = c + 1; stop = sched_deny(s, c + 1, 6);
      end else begin
        stop = sched_gate(s, c, code);
      end
      if (rst_phase != 0) begin
        rst_edge = (rst_phase == 1) ? c : c + 5;
        zero_from(rst_edge);
      end
    end

    MODE = m; id_valid = v; id_special = sp; chosen_flr_full = cf;
    alternative_flr_full = af; spec_flr_full = sf;
    accept_alt = 1'b0; reject_alt = 1'b0; id_submit = 1'b1;
    for (int ed = s + 1; ed <= stop + 1; ed++) begin
      tick();
      if (cyc == rst_edge) begin
        RST_N = 1'b0;
        #1;
        checkAllZero("async_rst");
        tick();
        tick();
        RST_N = 1'b1;
        clearInputs();
        return;
      end
      id_submit = dup && (ed == s + 3);
      MODE = (abort_edge != 0 && ed >= abort_edge) ? other : m;
      accept_alt = acc && (ed == ans_edge);
      reject_alt = rej && (ed == ans_edge);
    end
    clearInputs();
  endtask

  task automatic applyRestricted(input logic [1:0] m);
    busy_cnt = 0;
    MODE = m; id_valid = 1'b1;
    id_submit = 1'b1;
    tick();
    id_submit = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #2;
    checkAllZero("reset_state");
    chk_en = 1'b1;
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Enter, chosen floor free; a second submit mid-gate must be ignored.
    applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("direct_act_count", 16'(act_cnt), 16'd1);
    checkOutput("direct_act_code", 16'(last_act), 16'd2);
    checkOutput("direct_gate_len", 16'(gate_cnt), 16'd20);
    checkOutput("direct_reason", 16'(reason), 16'd1);

    // Chosen full, alternative accepted after 10 offer cycles.
    applyStimulus(2'd0, 1, 0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    checkOutput("alt_act_code", 16'(last_act), 16'd1);
    checkOutput("alt_offer_len", 16'(offer_cnt), 16'd10);
    checkOutput("alt_gate_len", 16'(gate_cnt), 16'd20);

    // Accept and reject together: reject wins.
    applyStimulus(2'd0, 1, 0, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0);
    checkOutput("both_act_count", 16'(act_cnt), 16'd0);
    checkOutput("both_deny_len", 16'(deny_cnt), 16'd9);
    checkOutput("both_reason", 16'(reason), 16'd4);

    // Offer timeout.
    applyStimulus(2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("timeout_offer_len", 16'(offer_cnt), 16'd12);
    checkOutput("timeout_reason", 16'(reason), 16'd5);

    // Accept arriving on the last offer cycle beats the timeout.
    applyStimulus(2'd0, 1, 0, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
    checkOutput("lastcyc_act_code", 16'(last_act), 16'd1);
    checkOutput("lastcyc_reason", 16'(reason), 16'd1);

    // Exit with valid and invalid ID.
    applyStimulus(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exit_act_code", 16'(last_act), 16'd3);
    checkOutput("exit_act_count", 16'(act_cnt), 16'd1);
    applyStimulus(2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exit_invalid_reason", 16'(reason), 16'd2);

    // Special ID with special floor full, then free.
    applyStimulus(2'd0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("special_full_reason", 16'(reason), 16'd3);
    applyStimulus(2'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("special_free_code", 16'(last_act), 16'd2);

    // Invalid enter and both floors full.
    applyStimulus(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("enter_invalid_reason", 16'(reason), 16'd2);
    applyStimulus(2'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("both_full_reason", 16'(reason), 16'd3);

    // Mode change aborts in OFFER, EVAL and COMMIT.
    applyStimulus(2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 4, 0, 0);
    checkOutput("abort_offer_len", 16'(offer_cnt), 16'd4);
    checkOutput("abort_offer_reason", 16'(reason), 16'd6);
    checkOutput("abort_offer_act", 16'(act_cnt), 16'd0);
    applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("abort_eval_reason", 16'(reason), 16'd6);
    applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    checkOutput("abort_commit_act", 16'(act_cnt), 16'd0);
    checkOutput("abort_commit_deny_len", 16'(deny_cnt), 16'd9);

    // Restricted mode submit is ignored; reason keeps the abort outcome.
    applyRestricted(2'd2);
    checkOutput("restricted_busy", 16'(busy_cnt), 16'd0);
    checkOutput("restricted_reason", 16'(reason), 16'd6);

    // Reset during GATE and during COMMIT, each followed by a fresh transaction.
    applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_gate_len", 16'(gate_cnt), 16'd20);
    applyStimulus(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("rst_commit_act", 16'(act_cnt), 16'd0);
    applyStimulus(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_exit_code", 16'(last_act), 16'd3);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
